// File: rtl/proc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// proc_pkg : opcode/state encodings and flag bit positions shared by proc_core
// Rev 1.0  : initial release
// ----------------------------------------------------------------------------
package proc_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_MUL   = 4'd2,
    OP_CMP   = 4'd3,
    OP_RSH   = 4'd4,
    OP_LSH   = 4'd5,
    OP_LOAD  = 4'd6,
    OP_STORE = 4'd7,
    OP_JMP   = 4'd8,
    OP_JE    = 4'd9,
    OP_JG    = 4'd10,
    OP_JL    = 4'd11,
    OP_LDI   = 4'd12,
    OP_SUB   = 4'd13,
    OP_RSVD  = 4'd14,
    OP_HALT  = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam int CARRY    = 0;
  localparam int OVERFLOW = 1;
  localparam int NEG      = 2;
  localparam int ZERO     = 3;

  function automatic logic sets_flags(input opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_CMP, OP_MUL, OP_RSH, OP_LSH};
  endfunction

  function automatic logic writes_back(input opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_RSH, OP_LSH, OP_LDI};
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// proc_alu : combinational ALU for proc_core, result plus {Z,N,V,C} flags
// Rev 1.0  : initial release
// ----------------------------------------------------------------------------
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_t           opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam logic [DATA_W-1:0] W_VAL = DATA_W'(DATA_W);
  localparam int                MSB   = DATA_W - 1;

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     lsh_w;
  logic [DATA_W:0]     rsh_w;
  logic                big_shift;
  logic                carry;
  logic                ovf;

  // Shifts run one bit wider so the last bit shifted out lands in the guard bit.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    prod      = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    lsh_w     = {1'b0, a} << b;
    rsh_w     = {a, 1'b0} >> b;
    big_shift = (b >= W_VAL);
    result    = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_MUL: begin
        result = prod[DATA_W-1:0];
        carry  = |prod[2*DATA_W-1:DATA_W];
        ovf    = carry;
      end
      OP_LSH: begin
        if (!big_shift) begin
          result = lsh_w[DATA_W-1:0];
          carry  = lsh_w[DATA_W];
        end
      end
      OP_RSH: begin
        if (!big_shift) begin
          result = rsh_w[DATA_W:1];
          carry  = rsh_w[0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    flags           = '0;
    flags[ZERO]     = (result == '0);
    flags[NEG]      = result[MSB];
    flags[OVERFLOW] = ovf;
    flags[CARRY]    = carry;
  end

endmodule
`default_nettype wire

// File: rtl/proc_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// proc_core : parametrised multi-cycle processor with valid/ready fetch port
// Rev 1.0   : initial release
// ----------------------------------------------------------------------------
module proc_core
  import proc_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int NREGS     = 4,
  parameter  int PC_W      = 4,
  parameter  int MEM_DEPTH = 16,
  parameter  int OUT_REG   = 2,
  localparam int RA        = $clog2(NREGS),
  localparam int INSTR_W   = 4 + 3 * RA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         proc_flags,
  output logic [DATA_W-1:0]  proc_out,
  output logic               halted
);

  localparam int             MA      = $clog2(MEM_DEPTH);
  localparam logic [RA-1:0]  OUT_IDX = RA'(OUT_REG);

  state_t              state;
  state_t              state_nx;
  logic [INSTR_W-1:0]  ir;
  opcode_t             op;
  logic [RA-1:0]       rd_f;
  logic [RA-1:0]       rs_f;
  logic [RA-1:0]       rt_f;

  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   mem  [MEM_DEPTH];
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   result;
  logic [DATA_W-1:0]   load_data;
  logic [3:0]          flags;

  logic [DATA_W-1:0]   alu_res;
  logic [3:0]          alu_flags;
  logic [DATA_W-1:0]   imm;
  logic [PC_W-1:0]     target;
  logic [MA-1:0]       addr;
  logic                cond;
  logic                taken;
  logic                to_fetch;

  assign op     = opcode_t'(ir[INSTR_W-1 -: 4]);
  assign rd_f   = ir[3*RA-1 -: RA];
  assign rs_f   = ir[2*RA-1 -: RA];
  assign rt_f   = ir[RA-1:0];
  assign imm    = DATA_W'({rs_f, rt_f});
  assign target = PC_W'(opa);
  assign addr   = opa[MA-1:0];

  proc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode (op),
    .a      (opa),
    .b      (opb),
    .result (alu_res),
    .flags  (alu_flags)
  );

  // Branch conditions see the flags as left by earlier instructions.
  always_comb begin
    cond = 1'b0;
    case (op)
      OP_JMP:  cond = 1'b1;
      OP_JE:   cond = flags[ZERO];
      OP_JG:   cond = !flags[ZERO] && (flags[NEG] == flags[OVERFLOW]);
      OP_JL:   cond = (flags[NEG] != flags[OVERFLOW]);
      default: cond = 1'b0;
    endcase
  end

  assign taken    = (state == S_EXECUTE) && cond;
  assign to_fetch = (state != S_FETCH) && (state_nx == S_FETCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: begin
        if (instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_NOP, OP_RSVD: state_nx = S_FETCH;
          OP_HALT:         state_nx = S_HALT;
          default:         state_nx = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        if (op == OP_LOAD || op == OP_STORE) state_nx = S_MEM;
        else if (writes_back(op))            state_nx = S_WB;
        else                                 state_nx = S_FETCH;
      end
      S_MEM:   state_nx = (op == OP_LOAD) ? S_WB : S_FETCH;
      S_WB:    state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  // instr_ready is gated by rst so it reads 0 for the whole reset window.
  always_comb begin
    instr_ready = rst && (state == S_FETCH);
    halted      = (state == S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= '0;
      flags     <= '0;
      ir        <= '0;
      opa       <= '0;
      opb       <= '0;
      result    <= '0;
      load_data <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (state == S_FETCH && instr_valid) ir <= instr;
      if (state == S_DECODE) begin
        opa <= regs[rs_f];
        opb <= regs[rt_f];
      end
      if (state == S_EXECUTE) begin
        result <= (op == OP_LDI) ? imm : alu_res;
        if (sets_flags(op)) flags <= alu_flags;
      end
      if (state == S_MEM && op == OP_LOAD) load_data <= mem[addr];
      if (state == S_WB) regs[rd_f] <= (op == OP_LOAD) ? load_data : result;
      if (to_fetch) pc <= taken ? target : pc + PC_W'(1);
    end
  end

  // Data memory has no reset; reset forces FETCH, so no store can slip through.
  always_ff @(posedge clk) begin
    if (state == S_MEM && op == OP_STORE) mem[addr] <= opb;
  end

  assign proc_flags = flags;
  assign proc_out   = regs[OUT_IDX];

endmodule
`default_nettype wire

// File: tb/tb_proc_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_proc_core : directed + random instruction stream against a reference model
// Rev 1.0      : initial release
// ----------------------------------------------------------------------------
module tb_proc_core;

  localparam int DATA_W    = 8;
  localparam int NREGS     = 4;
  localparam int PC_W      = 4;
  localparam int MEM_DEPTH = 16;
  localparam int OUT_REG   = 2;
  localparam int RA        = 2;
  localparam int INSTR_W   = 4 + 3 * RA;
  localparam int FULL      = 1 << DATA_W;
  localparam int SMAX      = (1 << (DATA_W - 1)) - 1;
  localparam int SMIN      = -(1 << (DATA_W - 1));

  logic               clk = 1'b0;
  logic               rst;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic [PC_W-1:0]    pc;
  logic [3:0]         proc_flags;
  logic [DATA_W-1:0]  proc_out;
  logic               halted;

  int n_checks = 0;
  int n_fail   = 0;

  int m_reg [NREGS];
  int m_mem [MEM_DEPTH];
  int m_pc;
  bit m_z, m_n, m_v, m_c;

  proc_core #(
    .DATA_W    (DATA_W),
    .NREGS     (NREGS),
    .PC_W      (PC_W),
    .MEM_DEPTH (MEM_DEPTH),
    .OUT_REG   (OUT_REG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .pc          (pc),
    .proc_flags  (proc_flags),
    .proc_out    (proc_out),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x > SMAX) ? x - FULL : x;
  endfunction

  function automatic logic [3:0] exp_flags();
    return {m_z, m_n, m_v, m_c};
  endfunction

  function automatic logic [INSTR_W-1:0] make_instr(input int op, input int rd, input int rs, input int rt);
    return {op[3:0], rd[RA-1:0], rs[RA-1:0], rt[RA-1:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_reg[i] = 0;
    m_pc = 0;
    m_z = 0; m_n = 0; m_v = 0; m_c = 0;
  endtask

  // Architectural effect of one instruction; lat = cycles incl. the handshake.
  task automatic model_exec(input int op, input int rd, input int rs, input int rt, output int lat);
    int  a, b, res, sr;
    longint p;
    bit  upd, taken, wr, c, v;
    a = m_reg[rs]; b = m_reg[rt];
    res = 0; c = 0; v = 0; upd = 0; taken = 0; wr = 0; lat = 2;
    case (op)
      1: begin
        res = (a + b) % FULL; c = (a + b) >= FULL;
        sr = to_signed(a) + to_signed(b); v = (sr > SMAX) || (sr < SMIN);
        upd = 1; wr = 1; lat = 4;
      end
      3, 13: begin
        res = (a - b + FULL) % FULL; c = (a < b);
        sr = to_signed(a) - to_signed(b); v = (sr > SMAX) || (sr < SMIN);
        upd = 1; wr = (op == 13); lat = (op == 13) ? 4 : 3;
      end
      2: begin
        p = longint'(a) * longint'(b);
        res = int'(p % FULL); c = (p >= FULL); v = c;
        upd = 1; wr = 1; lat = 4;
      end
      5: begin
        if (b < DATA_W) begin
          res = (a << b) % FULL;
          c = (b > 0) ? (((a >> (DATA_W - b)) & 1) != 0) : 1'b0;
        end
        upd = 1; wr = 1; lat = 4;
      end
      4: begin
        if (b < DATA_W) begin
          res = a >> b;
          c = (b > 0) ? (((a >> (b - 1)) & 1) != 0) : 1'b0;
        end
        upd = 1; wr = 1; lat = 4;
      end
      6:  begin res = m_mem[a % MEM_DEPTH]; wr = 1; lat = 5; end
      7:  begin m_mem[a % MEM_DEPTH] = b; lat = 4; end
      8:  begin taken = 1; lat = 3; end
      9:  begin taken = m_z; lat = 3; end
      10: begin taken = !m_z && (m_n == m_v); lat = 3; end
      11: begin taken = (m_n != m_v); lat = 3; end
      12: begin res = rs * NREGS + rt; wr = 1; lat = 4; end
      default: lat = 2;
    endcase
    if (upd) begin
      m_z = (res == 0); m_n = (res >= FULL / 2); m_v = v; m_c = c;
    end
    if (wr) m_reg[rd] = res;
    m_pc = taken ? (a % (1 << PC_W)) : ((m_pc + 1) % (1 << PC_W));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) check("ready_timeout", instr_ready, 1);
  endtask

  // Issues one instruction, feeds junk on instr/instr_valid while busy,
  // then checks latency and architectural outputs against the model.
  task automatic run_instr(input int op, input int rd, input int rs, input int rt);
    int lat, n;
    wait_ready();
    instr       = make_instr(op, rd, rs, rt);
    instr_valid = 1'b1;
    model_exec(op, rd, rs, rt, lat);
    @(posedge clk);
    @(negedge clk);
    n = 1;
    while (!instr_ready && n < 20) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr       = INSTR_W'($urandom);
      @(negedge clk);
      n++;
    end
    instr_valid = 1'b0;
    check("latency", n, lat);
    check("pc", pc, m_pc);
    check("flags", proc_flags, exp_flags());
    check("out", proc_out, m_reg[OUT_REG]);
  endtask

  task automatic ldi(input int rd, input int val);
    run_instr(12, rd, val >> RA, val % NREGS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    model_reset();
    for (int i = 0; i < MEM_DEPTH; i++) m_mem[i] = 0;

    repeat (2) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_flags", proc_flags, 0);
    check("rst_out", proc_out, 0);
    check("rst_halted", halted, 0);
    check("rst_ready", instr_ready, 0);
    rst = 1'b1;
    #1;
    check("release_ready", instr_ready, 1);

    // LDI/LDI/ADD
    ldi(0, 5); ldi(1, 3); run_instr(1, 2, 0, 1);
    check("tp1_out", proc_out, 8'h08);
    check("tp1_flags", proc_flags, 4'b0000);
    check("tp1_pc", pc, 3);

    // shift then carry-out add
    ldi(0, 15); ldi(1, 4); run_instr(5, 0, 0, 1);
    check("tp2_lsh_flags", proc_flags, 4'b0100);
    run_instr(1, 2, 0, 0);
    check("tp2_add_out", proc_out, 8'hE0);
    check("tp2_add_flags", proc_flags, 4'b0101);

    // signed compare and branches
    ldi(0, 3); ldi(1, 5); ldi(3, 9);
    run_instr(3, 0, 0, 1);
    check("tp3_cmp_flags", proc_flags, 4'b0101);
    run_instr(11, 0, 3, 0);
    check("tp3_jl_pc", pc, 9);
    run_instr(9, 0, 3, 0);
    check("tp3_je_pc", pc, 10);

    // store / load round trip
    ldi(0, 6); ldi(1, 10);
    run_instr(7, 0, 0, 1);
    run_instr(6, 2, 0, 0);
    check("tp4_load_out", proc_out, 8'h0A);

    // give every memory word a known value
    for (int a = 0; a < MEM_DEPTH; a++) begin
      ldi(0, a);
      ldi(1, int'($urandom_range(0, 15)));
      run_instr(7, 0, 0, 1);
    end

    for (int i = 0; i < 250; i++)
      run_instr(int'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // idle in FETCH
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b0;
      instr       = INSTR_W'($urandom);
      @(negedge clk);
      check("idle_ready", instr_ready, 1);
      check("idle_pc", pc, m_pc);
    end

    // reset during EXECUTE of ADD r2
    ldi(0, 7); ldi(1, 9);
    wait_ready();
    instr       = make_instr(1, 2, 0, 1);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check("midrst_pc", pc, 0);
    check("midrst_out", proc_out, 0);
    check("midrst_flags", proc_flags, 0);
    check("midrst_halted", halted, 0);
    check("midrst_ready", instr_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_release_ready", instr_ready, 1);
    check("midrst_release_out", proc_out, 0);
    run_instr(1, 2, 0, 1);
    ldi(0, 12); ldi(1, 3);
    run_instr(13, 2, 1, 0);

    for (int i = 0; i < 30; i++)
      run_instr(int'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // HALT holds the core regardless of instr_valid
    wait_ready();
    instr       = make_instr(15, 0, 0, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      instr_valid = 1'b1;
      instr       = INSTR_W'($urandom);
      @(negedge clk);
      check("halt_halted", halted, 1);
      check("halt_ready", instr_ready, 0);
      check("halt_pc", pc, m_pc);
      check("halt_flags", proc_flags, exp_flags());
    end
    instr_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
